mem_access_unit: RTL and testbench

//  Parametrised MEM-stage engine for the pipelined MIPS core. Decodes load/store

---
 rtl/mem_access_unit_if.sv | 49 ++++
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// EX/MEM/WB and data-memory signals of the MEM-stage access unit.
// The slave modport is the unit itself; the master modport is its environment.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TNEW_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_op;
  logic [DATA_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic [DATA_W-1:0]   in_pc;
  logic [REG_W-1:0]    in_dst;
  logic [DATA_W-1:0]   in_res;
  logic                in_we;
  logic [TNEW_W-1:0]   in_tnew;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_wd;
  logic [REG_W-1:0]    out_dst;
  logic                out_we;
  logic [TNEW_W-1:0]   out_tnew;
  logic [DATA_W-1:0]   out_pc;
  logic [1:0]          out_err;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_pc, in_dst, in_res, in_we, in_tnew,
    input  mem_rdata, mem_ack, out_ready,
    output in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output out_valid, out_wd, out_dst, out_we, out_tnew, out_pc, out_err
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_pc, in_dst, in_res, in_we, in_tnew,
    output mem_rdata, mem_ack, out_ready,
    input  in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  out_valid, out_wd, out_dst, out_we, out_tnew, out_pc, out_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage engine: decodes load/store width, runs a req/ack data-memory access
// with timeout, stalls EX while busy and registers the result toward WB.
//
// state  | meaning
// S_IDLE | no access outstanding; may accept from EX when the WB slot is free
// S_BUSY | memory request held until mem_ack or wait-timer terminal count
module mem_access_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int TNEW_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input logic                clk,
  input logic                reset,
  mem_access_unit_if.slave   io_bus
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam bit TO_EN = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] CNT_INIT = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  logic [0:0]        r_state;
  logic              r_req;
  logic              r_mem_we;
  logic [NB-1:0]     r_mem_be;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_op;
  logic [1:0]        r_lo;
  logic [REG_W-1:0]  r_dst;
  logic [DATA_W-1:0] r_pc;
  logic [TNEW_W-1:0] r_tnew;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_wd;
  logic [REG_W-1:0]  r_out_dst;
  logic              r_out_we;
  logic [TNEW_W-1:0] r_out_tnew;
  logic [DATA_W-1:0] r_out_pc;
  logic [1:0]        r_out_err;

  logic              w_is_word;
  logic              w_is_half;
  logic              w_is_byte;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misal;
  logic              w_out_free;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_start;
  logic              w_load_direct;
  logic              w_done;
  logic              w_timeout;
  logic              w_r_is_load;
  logic [TNEW_W-1:0] w_tnew_dec;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [15:0]       w_lane_h;
  logic [7:0]        w_lane_b;
  logic [DATA_W-1:0] w_ld;

  assign w_is_word  = (io_bus.in_op == OP_LW) || (io_bus.in_op == OP_SW);
  assign w_is_half  = (io_bus.in_op == OP_LH) || (io_bus.in_op == OP_LHU) || (io_bus.in_op == OP_SH);
  assign w_is_byte  = (io_bus.in_op == OP_LB) || (io_bus.in_op == OP_LBU) || (io_bus.in_op == OP_SB);
  assign w_is_store = (io_bus.in_op == OP_SW) || (io_bus.in_op == OP_SH) || (io_bus.in_op == OP_SB);
  assign w_is_mem   = w_is_word || w_is_half || w_is_byte;
  assign w_misal    = (w_is_word && (io_bus.in_addr[1:0] != 2'b00)) ||
                      (w_is_half && io_bus.in_addr[0]);

  assign w_out_free    = !r_out_valid || io_bus.out_ready;
  assign w_in_ready    = (r_state == S_IDLE) && w_out_free;
  assign w_accept      = io_bus.in_valid && w_in_ready;
  assign w_start       = w_accept && w_is_mem && !w_misal;
  assign w_load_direct = w_accept && (!w_is_mem || w_misal);
  assign w_done        = (r_state == S_BUSY) && io_bus.mem_ack;
  // ack in the terminal-count cycle still wins over the timeout
  assign w_timeout     = TO_EN && (r_state == S_BUSY) && !io_bus.mem_ack && (r_cnt == '0);
  assign w_r_is_load   = (r_op == OP_LW) || (r_op == OP_LH) || (r_op == OP_LHU) ||
                         (r_op == OP_LB) || (r_op == OP_LBU);

  assign w_tnew_dec = (io_bus.in_tnew == '0) ? '0 : io_bus.in_tnew - TNEW_W'(1);

  always_comb begin
    w_be    = '0;
    w_wdata = io_bus.in_wdata;
    if (w_is_word) begin
      w_be = '1;
    end else if (w_is_half) begin
      w_be    = NB'(2'b11) << {io_bus.in_addr[1], 1'b0};
      w_wdata = {(DATA_W/16){io_bus.in_wdata[15:0]}};
    end else if (w_is_byte) begin
      w_be    = NB'(1) << io_bus.in_addr[1:0];
      w_wdata = {NB{io_bus.in_wdata[7:0]}};
    end
  end

  assign w_lane_h = r_lo[1] ? io_bus.mem_rdata[31:16] : io_bus.mem_rdata[15:0];

  always_comb begin
    w_lane_b = 8'h00;
    case (r_lo)
      2'd0:    w_lane_b = io_bus.mem_rdata[7:0];
      2'd1:    w_lane_b = io_bus.mem_rdata[15:8];
      2'd2:    w_lane_b = io_bus.mem_rdata[23:16];
      default: w_lane_b = io_bus.mem_rdata[31:24];
    endcase
  end

  always_comb begin
    w_ld = '0;
    case (r_op)
      OP_LW:   w_ld = io_bus.mem_rdata;
      OP_LH:   w_ld = {{(DATA_W-16){w_lane_h[15]}}, w_lane_h};
      OP_LHU:  w_ld = {{(DATA_W-16){1'b0}}, w_lane_h};
      OP_LB:   w_ld = {{(DATA_W-8){w_lane_b[7]}}, w_lane_b};
      OP_LBU:  w_ld = {{(DATA_W-8){1'b0}}, w_lane_b};
      default: w_ld = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_op        <= 4'd0;
      r_lo        <= 2'd0;
      r_dst       <= '0;
      r_pc        <= '0;
      r_tnew      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_BUSY;
            r_req       <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_be    <= w_be;
            r_mem_addr  <= {io_bus.in_addr[DATA_W-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_op        <= io_bus.in_op;
            r_lo        <= io_bus.in_addr[1:0];
            r_dst       <= io_bus.in_dst;
            r_pc        <= io_bus.in_pc;
            r_tnew      <= w_tnew_dec;
            r_cnt       <= CNT_INIT;
          end
        end
        S_BUSY: begin
          if (w_done || w_timeout) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (TO_EN) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // WB slot: loads on any new result, otherwise drains when WB takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_wd    <= '0;
      r_out_dst   <= '0;
      r_out_we    <= 1'b0;
      r_out_tnew  <= '0;
      r_out_pc    <= '0;
      r_out_err   <= 2'd0;
    end else if (w_load_direct) begin
      r_out_valid <= 1'b1;
      r_out_dst   <= io_bus.in_dst;
      r_out_tnew  <= w_tnew_dec;
      r_out_pc    <= io_bus.in_pc;
      r_out_wd    <= w_misal ? '0 : io_bus.in_res;
      r_out_we    <= w_misal ? 1'b0 : io_bus.in_we;
      r_out_err   <= w_misal ? 2'd1 : 2'd0;
    end else if (w_done || w_timeout) begin
      r_out_valid <= 1'b1;
      r_out_dst   <= r_dst;
      r_out_tnew  <= r_tnew;
      r_out_pc    <= r_pc;
      r_out_wd    <= w_done ? w_ld : '0;
      r_out_we    <= w_done && w_r_is_load;
      r_out_err   <= w_done ? 2'd0 : 2'd2;
    end else if (io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.mem_req   = r_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_wd    = r_out_wd;
  assign io_bus.out_dst   = r_out_dst;
  assign io_bus.out_we    = r_out_we;
  assign io_bus.out_tnew  = r_out_tnew;
  assign io_bus.out_pc    = r_out_pc;
  assign io_bus.out_err   = r_out_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scoreboard queue of expected WB
// results, filled when each instruction is driven and drained on out_valid.
module tb_mem_access_unit;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int TNEW_W   = 4;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic [31:0] wd;
    logic [4:0]  dst;
    logic        we;
    logic [3:0]  tnew;
    logic [31:0] pc;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DATA_W), .REG_W(REG_W), .TNEW_W(TNEW_W)) bus ();

  mem_access_unit #(
    .DATA_W(DATA_W), .REG_W(REG_W), .TNEW_W(TNEW_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] res, input logic we,
                                 input logic [4:0] dst, input logic [31:0] pc,
                                 input logic [3:0] tnew, input logic [31:0] rdata,
                                 input bit tmo);
    exp_t e;
    logic [15:0] h;
    logic [7:0] b;
    bit is_w, is_h, is_b;
    is_w = (op == 4'd1) || (op == 4'd6);
    is_h = (op == 4'd2) || (op == 4'd3) || (op == 4'd7);
    is_b = (op == 4'd4) || (op == 4'd5) || (op == 4'd8);
    e.dst = dst;
    e.pc = pc;
    e.tnew = (tnew == 4'd0) ? 4'd0 : tnew - 4'd1;
    e.wd = 32'h0;
    e.we = 1'b0;
    e.err = 2'd0;
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr[1:0])
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    if (!(is_w || is_h || is_b)) begin
      e.wd = res;
      e.we = we;
    end else if ((is_w && addr[1:0] != 2'b00) || (is_h && addr[0])) begin
      e.err = 2'd1;
    end else if (tmo) begin
      e.err = 2'd2;
    end else begin
      case (op)
        4'd1: begin e.wd = rdata; e.we = 1'b1; end
        4'd2: begin e.wd = {{16{h[15]}}, h}; e.we = 1'b1; end
        4'd3: begin e.wd = {16'h0, h}; e.we = 1'b1; end
        4'd4: begin e.wd = {{24{b[7]}}, b}; e.we = 1'b1; end
        4'd5: begin e.wd = {24'h0, b}; e.we = 1'b1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
    if (op == 4'd1 || op == 4'd6) return 4'hF;
    if (op == 4'd2 || op == 4'd3 || op == 4'd7) return addr[1] ? 4'hC : 4'h3;
    case (addr[1:0])
      2'd0: return 4'h1;
      2'd1: return 4'h2;
      2'd2: return 4'h4;
      default: return 4'h8;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] w);
    if (op == 4'd7) return {2{w[15:0]}};
    if (op == 4'd8) return {4{w[7:0]}};
    return w;
  endfunction

  task automatic drive_in(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] res,
                          input logic we, input logic [3:0] tnew);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
    bus.in_pc    = pc;
    bus.in_dst   = dst;
    bus.in_res   = res;
    bus.in_we    = we;
    bus.in_tnew  = tnew;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] dst,
                       input logic [31:0] res, input logic we, input logic [3:0] tnew);
    int n;
    drive_in(op, addr, wdata, pc, dst, res, we, tnew);
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_wd"},   bus.out_wd, e.wd);
      chk({tag, "_dst"},  32'(bus.out_dst), 32'(e.dst));
      chk({tag, "_we"},   32'(bus.out_we), 32'(e.we));
      chk({tag, "_tnew"}, 32'(bus.out_tnew), 32'(e.tnew));
      chk({tag, "_pc"},   bus.out_pc, e.pc);
      chk({tag, "_err"},  32'(bus.out_err), 32'(e.err));
    end
  endtask

  task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dst, input logic [31:0] pc,
                        input logic [3:0] tnew, input logic [31:0] rdata, input int waits);
    int lowcnt;
    sb_q.push_back(model(op, addr, 32'h0, 1'b0, dst, pc, tnew, rdata, 1'b0));
    issue(tag, op, addr, wdata, pc, dst, 32'h5A5A5A5A, 1'b1, tnew);
    chk({tag, "_mem_req"},  32'(bus.mem_req), 32'd1);
    chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mem_be"},   32'(bus.mem_be), 32'(exp_be(op, addr)));
    chk({tag, "_mem_we"},   32'(bus.mem_we), (op >= 4'd6) ? 32'd1 : 32'd0);
    if (op >= 4'd6) chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata(op, wdata));
    lowcnt = 0;
    for (int i = 0; i <= waits; i++) begin
      if (!bus.in_ready) lowcnt++;
      bus.mem_ack   = (i == waits);
      bus.mem_rdata = (i == waits) ? rdata : $urandom;
      step();
    end
    bus.mem_ack = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(lowcnt), 32'(waits + 1));
    chk({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    expect_out(tag);
  endtask

  initial begin
    int reqcnt;
    int n;
    bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.in_pc = '0; bus.in_dst = '0; bus.in_res = '0; bus.in_we = 1'b0; bus.in_tnew = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rst_out_wd",    bus.out_wd, 32'd0);
    chk("rst_out_err",   32'(bus.out_err), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    step();

    mem_op("lw",  4'd1, 32'h10, 32'h0, 5'd3, 32'h400, 4'd3, 32'hDEADBEEF, 3);
    mem_op("lb",  4'd4, 32'h13, 32'h0, 5'd5, 32'h404, 4'd0, 32'h80FF0000, 0);
    mem_op("lbu", 4'd5, 32'h13, 32'h0, 5'd6, 32'h408, 4'd2, 32'h80FF0000, 1);
    mem_op("lh",  4'd2, 32'h12, 32'h0, 5'd7, 32'h40C, 4'd5, 32'h80FF0000, 0);
    mem_op("lhu", 4'd3, 32'h10, 32'h0, 5'd8, 32'h410, 4'd1, 32'h12348765, 2);
    mem_op("sh",  4'd7, 32'h22, 32'h1234ABCD, 5'd9, 32'h414, 4'd2, 32'hFFFFFFFF, 0);
    mem_op("sb",  4'd8, 32'h21, 32'h55AA77CD, 5'd10, 32'h418, 4'd1, 32'h0, 2);
    mem_op("sw",  4'd6, 32'h24, 32'hCAFEF00D, 5'd11, 32'h41C, 4'd0, 32'h0, 0);

    sb_q.push_back(model(4'd1, 32'h11, 32'h77, 1'b1, 5'd12, 32'h420, 4'd4, 32'h0, 1'b0));
    issue("mis_lw", 4'd1, 32'h11, 32'h0, 32'h420, 5'd12, 32'h77, 1'b1, 4'd4);
    chk("mis_lw_no_req", 32'(bus.mem_req), 32'd0);
    expect_out("mis_lw");
    sb_q.push_back(model(4'd7, 32'h23, 32'h88, 1'b1, 5'd13, 32'h424, 4'd1, 32'h0, 1'b0));
    issue("mis_sh", 4'd7, 32'h23, 32'hFFFF, 32'h424, 5'd13, 32'h88, 1'b1, 4'd1);
    chk("mis_sh_no_req", 32'(bus.mem_req), 32'd0);
    expect_out("mis_sh");
    step();

    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h13572468;
    step();
    bus.mem_ack = 1'b0;
    chk("idle_ack_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_ack_mem_req",   32'(bus.mem_req), 32'd0);
    chk("idle_ack_in_ready",  32'(bus.in_ready), 32'd1);

    sb_q.push_back(model(4'd1, 32'h40, 32'h0, 1'b1, 5'd14, 32'h428, 4'd3, 32'h0, 1'b1));
    issue("tmo", 4'd1, 32'h40, 32'h0, 32'h428, 5'd14, 32'h0, 1'b1, 4'd3);
    bus.out_ready = 1'b0;
    reqcnt = 0;
    n = 0;
    while (bus.mem_req && n < 20) begin
      reqcnt++;
      step();
      n++;
    end
    chk("tmo_req_cycles", 32'(reqcnt), 32'(MAX_WAIT));
    for (int i = 0; i < 3; i++) begin
      chk("tmo_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("tmo_hold_err",   32'(bus.out_err), 32'd2);
      chk("tmo_hold_pc",    bus.out_pc, 32'h428);
      chk("tmo_hold_stall", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    expect_out("tmo");
    step();

    sb_q.push_back(model(4'd0, 32'h0, 32'h11111111, 1'b1, 5'd15, 32'h500, 4'd2, 32'h0, 1'b0));
    sb_q.push_back(model(4'd9, 32'h3, 32'h22222222, 1'b0, 5'd16, 32'h504, 4'd0, 32'h0, 1'b0));
    drive_in(4'd0, 32'h0, 32'h0, 32'h500, 5'd15, 32'h11111111, 1'b1, 4'd2);
    step();
    expect_out("b2b0");
    drive_in(4'd9, 32'h3, 32'h0, 32'h504, 5'd16, 32'h22222222, 1'b0, 4'd0);
    step();
    bus.in_valid = 1'b0;
    chk("b2b1_consecutive", 32'(bus.out_valid), 32'd1);
    expect_out("b2b1");
    step();

    issue("abort", 4'd1, 32'h80, 32'h0, 32'h600, 5'd17, 32'h0, 1'b0, 4'd1);
    chk("abort_req_high", 32'(bus.mem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_req_low",   32'(bus.mem_req), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    #1 reset = 1'b1;
    step();
    step();
    chk("abort_no_result", 32'(bus.out_valid), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
